// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed operation is selected by defining SIGNED_DIV_EN.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor: minuend + ~subtrahend + 1, ripple carry.
// borrow is the inverted carry out of the top bit.
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] difference,
    output logic         borrow
);

    logic [W-1:0] b_inv;
    logic [W:0]   carry;

    assign b_inv = subtrahend ^ {W{1'b1}};

    always_comb begin
        carry[0]   = 1'b1;
        difference = '0;
        for (int i = 0; i < W; i++) begin
            difference[i] = minuend[i] ^ b_inv[i] ^ carry[i];
            carry[i+1]    = (minuend[i] & b_inv[i])
                          | (carry[i] & (minuend[i] ^ b_inv[i]));
        end
    end

    assign borrow = ~carry[W];

endmodule

// File: rtl/eight_bit_restoring_div.sv
// Sequential restoring divider, one trial subtraction per clock.
// Define SIGNED_DIV_EN for two's complement operands (adds a FIX cycle).
module eight_bit_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   minuend;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             unused_bits;

    // Bit shifted out of R becomes the trial's MSB, so wide remainders survive.
    assign minuend = {r_reg, q_reg[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_sub (
        .minuend    (minuend),
        .subtrahend ({1'b0, dvs_reg}),
        .difference (diff),
        .borrow     (borrow)
    );

    assign r_next      = borrow ? minuend[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next      = {q_reg[WIDTH-2:0], ~borrow};
    assign unused_bits = ^{minuend[WIDTH], diff[WIDTH]};
    assign done        = (state == DONE);

`ifdef SIGNED_DIV_EN
    logic dvd_neg;
    logic q_neg;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign busy    = (state == RUN) || (state == FIX);
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign busy    = (state == RUN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            dvd_neg     <= 1'b0;
            q_neg       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        cnt     <= '0;
                        r_reg   <= '0;
                        q_reg   <= dvd_mag;
                        dvs_reg <= dvs_mag;
`ifdef SIGNED_DIV_EN
                        dvd_neg <= dividend[WIDTH-1];
                        q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= {WIDTH{DIV0_QUOTIENT[0]}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
`ifdef SIGNED_DIV_EN
                        state <= FIX;
`else
                        state       <= DONE;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                FIX: begin
                    state       <= DONE;
                    div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
                    quotient    <= q_neg ? -q_reg : q_reg;
                    remainder   <= dvd_neg ? -r_reg : r_reg;
`else
                    quotient    <= q_reg;
                    remainder   <= r_reg;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eight_bit_restoring_div.sv
// Self-checking bench for eight_bit_restoring_div against an arithmetic model.
// Honours SIGNED_DIV_EN when the design is built with it.
module tb_eight_bit_restoring_div;

    localparam int W = 8;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int           n_tests = 0;
    int           n_fail = 0;
    int           got_lat;
    int           got_busy;
    logic [W-1:0] got_q;
    logic [W-1:0] got_r;
    logic         got_z;

    eight_bit_restoring_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
        int sa;
        int sb;
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts in the cycle after the accepting edge; got_lat counts edges.
    task automatic wait_done(input string tag);
        got_lat  = 0;
        got_busy = 0;
        while (!done && got_lat < 40) begin
            if (busy) got_busy++;
            @(negedge clk);
            got_lat++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        got_q = quotient;
        got_r = remainder;
        got_z = div_by_zero;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        model(a, b, eq, er, ez);
        launch(a, b);
        wait_done(tag);
        check({tag, "_q"}, got_q, eq);
        check({tag, "_r"}, got_r, er);
        check({tag, "_dz"}, got_z, ez);
        check({tag, "_lat"}, got_lat, ez ? 0 : LAT);
        check({tag, "_busy_cyc"}, got_busy, ez ? 0 : LAT);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           pulses;

        repeat (2) @(negedge clk);
        check("reset_out", {busy, done, div_by_zero, quotient, remainder}, 0);
        rst_n = 1'b1;

`ifdef SIGNED_DIV_EN
        run_op(8'h9C, 8'd7, "s_m100_7");
        check("s_m100_7_qc", got_q, 8'hF2);
        check("s_m100_7_rc", got_r, 8'hFE);
        run_op(8'h80, 8'hFF, "s_m128_m1");
        check("s_m128_m1_qc", got_q, 8'h80);
        check("s_m128_m1_rc", got_r, 8'h00);
        check("s_m128_m1_dz", got_z, 0);
`else
        run_op(8'd200, 8'd7, "u200_7");
        check("u200_7_qc", got_q, 8'h1C);
        check("u200_7_rc", got_r, 8'd4);
        run_op(8'd255, 8'd1, "u255_1");
        check("u255_1_qc", got_q, 8'd255);
        check("u255_1_rc", got_r, 8'd0);
        run_op(8'd5, 8'd10, "u5_10");
        check("u5_10_qc", got_q, 8'd0);
        check("u5_10_rc", got_r, 8'd5);
`endif
        run_op(8'd37, 8'd0, "div0");
        check("div0_qc", got_q, 8'hFF);
        check("div0_rc", got_r, 8'd37);
        check("div0_dzc", got_z, 1);

        // Outputs must hold while idle.
        run_op(8'd5, 8'd10, "hold");
        model(8'd5, 8'd10, eq, er, ez);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("hold_pulses", pulses, 0);
        check("hold_q", quotient, eq);
        check("hold_r", remainder, er);

        // start during RUN is ignored, operands are not re-latched.
        model(8'd200, 8'd7, eq, er, ez);
        launch(8'd200, 8'd7);
        repeat (2) @(negedge clk);
        dividend = 8'd3;
        divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        check("ign_q", got_q, eq);
        check("ign_r", got_r, er);

        // start held through DONE begins the next operation at once.
        @(negedge clk);
        model(8'd100, 8'd9, eq, er, ez);
        launch(8'd100, 8'd9);
        wait_done("b2b_a");
        check("b2b_a_q", got_q, eq);
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_drop", done, 0);
        check("b2b_busy", busy, 1);
        model(8'd255, 8'd1, eq, er, ez);
        wait_done("b2b_b");
        check("b2b_b_q", got_q, eq);
        check("b2b_b_r", got_r, er);
        check("b2b_b_lat", got_lat, LAT);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        launch(8'd200, 8'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {busy, done, div_by_zero, quotient, remainder}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd100, 8'd9, "after_rst");
        check("after_rst_qc", got_q, 8'd11);
        check("after_rst_rc", got_r, 8'd1);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 8 == 7) ? '0 : W'($urandom_range(0, 255));
            run_op(a, b, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
